// File: rtl/ltc2500_sched_pkg.sv
// rtl/ltc2500_sched_pkg.sv - shared state type, default timing constants and period clamp for the LTC2500 sample scheduler
package ltc2500_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    GUARD,
    RUN,
    DRAIN
  } state_t;

  localparam int DEF_MIN_PERIOD   = 40;
  localparam int DEF_SYNC_LEN     = 4;
  localparam int DEF_SYNC_GUARD   = 8;
  localparam int DEF_FILT_TIMEOUT = 256;

  // The programmed period is spacing-1, so the floor on the reload value is min_period-1.
  function automatic int clamp_period(input int p, input int min_period);
    return (p < min_period - 1) ? (min_period - 1) : p;
  endfunction

endpackage

// File: rtl/ltc2500_period_timer.sv
// rtl/ltc2500_period_timer.sv - loadable down-counter with zero strobe and clamped auto-reload
module ltc2500_period_timer
  import ltc2500_sched_pkg::*;
#(
  parameter int W          = 16,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         zero
);

  logic [W-1:0] cnt;
  logic [W-1:0] reload;

  assign reload = W'(clamp_period(int'(period), MIN_PERIOD));
  assign zero   = (cnt == '0);

  // Count down while enabled; reaching zero reloads so the strobe repeats every reload+1 cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= zero ? reload : (cnt - W'(1));
    end
  end

endmodule

// File: rtl/ltc2500_sample_scheduler.sv
// rtl/ltc2500_sample_scheduler.sv - LTC2500 go/sync sequencer with decimation tracking; optional LTC2500_SCHED_TIMESTAMP_EN
module ltc2500_sample_scheduler
  import ltc2500_sched_pkg::*;
#(
  parameter int PERIOD_W     = 16,
  parameter int MIN_PERIOD   = DEF_MIN_PERIOD,
  parameter int SYNC_LEN     = DEF_SYNC_LEN,
  parameter int SYNC_GUARD   = DEF_SYNC_GUARD,
  parameter int FILT_TIMEOUT = DEF_FILT_TIMEOUT,
  parameter int OVR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [PERIOD_W-1:0]  period,
  input  logic [3:0]           decim_log2,
  input  logic                 resync,
  input  logic                 done,
  input  logic                 done_filt,
  output logic                 go,
  output logic                 sync_req,
  output logic                 running,
  output logic                 filt_due,
  output logic                 overrun,
  output logic [OVR_CNT_W-1:0] overrun_cnt,
  output logic                 filt_err,
  input  logic                 err_clr
`ifdef LTC2500_SCHED_TIMESTAMP_EN
  ,
  output logic [31:0]          ts_filt,
  output logic                 ts_valid
`endif
);

  localparam int PH_W = 8;
  localparam int WD_W = $clog2(FILT_TIMEOUT + 1);

  state_t          state;
  logic [PH_W-1:0] phase_cnt;
  logic            resync_pend;
  logic            busy;
  logic [3:0]      decim_lat;
  logic [14:0]     decim_cnt;
  logic [14:0]     decim_mask;
  logic            wd_armed;
  logic [WD_W-1:0] wd_cnt;

  logic timer_zero;
  logic timer_en;
  logic guard_last;
  logic run_stay;
  logic slot;
  logic slot_go;
  logic slot_skip;
  logic filt_hit;
  logic filt_err_set;

  // The last GUARD cycle doubles as the first slot so go appears in the first RUN cycle.
  assign guard_last = (state == GUARD) && enable && (phase_cnt == PH_W'(SYNC_GUARD - 1));
  // A cycle that leaves RUN never fires a slot, so nothing is issued after a resync or disable.
  assign run_stay   = (state == RUN) && enable && !resync;
  assign timer_en   = run_stay || guard_last;
  assign slot       = timer_zero && timer_en;
  assign slot_go    = slot && !busy;
  assign slot_skip  = slot && busy;
  assign decim_mask = 15'((16'd1 << decim_lat) - 16'd1);
  assign filt_hit   = slot_go && (decim_cnt == decim_mask);
  // Expiry, or a new window closing before the previous filtered read came back.
  assign filt_err_set = wd_armed && !done_filt && (filt_hit || (wd_cnt == WD_W'(1)));

  // Outside the slot window the timer is parked at 0 so the first RUN slot fires at once.
  ltc2500_period_timer #(
    .W          (PERIOD_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (!timer_en),
    .load_val ('0),
    .en       (timer_en),
    .period   (period),
    .zero     (timer_zero)
  );

  // Sequencing FSM: sync pulse, guard gap, run, and drain of in-flight reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      resync_pend <= 1'b0;
      decim_lat   <= '0;
      sync_req    <= 1'b0;
      running     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state     <= SYNC;
            sync_req  <= 1'b1;
            phase_cnt <= '0;
          end
        end
        SYNC: begin
          if (!enable) begin
            state    <= IDLE;
            sync_req <= 1'b0;
          end else if (phase_cnt == PH_W'(SYNC_LEN - 1)) begin
            state     <= GUARD;
            sync_req  <= 1'b0;
            phase_cnt <= '0;
            decim_lat <= decim_log2;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        GUARD: begin
          if (!enable) begin
            state <= IDLE;
          end else if (guard_last) begin
            state   <= RUN;
            running <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        RUN: begin
          if (!enable) begin
            state       <= DRAIN;
            running     <= 1'b0;
            resync_pend <= 1'b0;
          end else if (resync) begin
            state       <= DRAIN;
            running     <= 1'b0;
            resync_pend <= 1'b1;
          end
        end
        DRAIN: begin
          if (!busy && !wd_armed) begin
            if (resync_pend && enable) begin
              state     <= SYNC;
              sync_req  <= 1'b1;
              phase_cnt <= '0;
            end else begin
              state <= IDLE;
            end
            resync_pend <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          sync_req <= 1'b0;
          running  <= 1'b0;
        end
      endcase
    end
  end

  // Slot outcome: issue go or record an overrun; track conversion busy and the decimation phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      go          <= 1'b0;
      filt_due    <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
      overrun_cnt <= '0;
      decim_cnt   <= '0;
    end else begin
      go       <= slot_go;
      filt_due <= filt_hit;
      overrun  <= slot_skip;

      if (slot_go) begin
        busy <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end

      if (err_clr) begin
        overrun_cnt <= '0;
      end else if (slot_skip && (overrun_cnt != '1)) begin
        overrun_cnt <= overrun_cnt + OVR_CNT_W'(1);
      end

      if (slot_go) begin
        decim_cnt <= filt_hit ? 15'd0 : (decim_cnt + 15'd1);
      end else if ((state == SYNC) || (state == GUARD)) begin
        decim_cnt <= '0;
      end
    end
  end

  // Filtered-data watchdog: armed by each window-closing go, cleared by done_filt or expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_armed <= 1'b0;
      wd_cnt   <= '0;
      filt_err <= 1'b0;
    end else begin
      if (filt_hit) begin
        wd_armed <= 1'b1;
        wd_cnt   <= WD_W'(FILT_TIMEOUT);
      end else if (done_filt) begin
        wd_armed <= 1'b0;
        wd_cnt   <= '0;
      end else if (wd_armed) begin
        if (wd_cnt == WD_W'(1)) begin
          wd_armed <= 1'b0;
          wd_cnt   <= '0;
        end else begin
          wd_cnt <= wd_cnt - WD_W'(1);
        end
      end

      if (err_clr) begin
        filt_err <= 1'b0;
      end else if (filt_err_set) begin
        filt_err <= 1'b1;
      end
    end
  end

`ifdef LTC2500_SCHED_TIMESTAMP_EN
  logic [31:0] cycle_cnt;
  logic [31:0] ts_lat;

  // Stamp each window-closing go and present the stamp when its filtered read completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      ts_lat    <= '0;
      ts_filt   <= '0;
      ts_valid  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      ts_valid  <= 1'b0;
      if (filt_hit) begin
        ts_lat <= cycle_cnt;
      end
      if (done_filt && wd_armed) begin
        ts_valid <= 1'b1;
        ts_filt  <= ts_lat;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ltc2500_sample_scheduler.sv
// tb/tb_ltc2500_sample_scheduler.sv - scoreboard bench for the LTC2500 sample scheduler
module tb_ltc2500_sample_scheduler;

  localparam int PERIOD_W  = 16;
  localparam int OVR_CNT_W = 8;

  logic                 clk = 1'b0;
  logic                 reset, enable, resync, done, done_filt, err_clr;
  logic [PERIOD_W-1:0]  period;
  logic [3:0]           decim_log2;
  logic                 go, sync_req, running, filt_due, overrun, filt_err;
  logic [OVR_CNT_W-1:0] overrun_cnt;
`ifdef LTC2500_SCHED_TIMESTAMP_EN
  logic [31:0]          ts_filt;
  logic                 ts_valid;
`endif

  always #5 clk = ~clk;

  ltc2500_sample_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .period      (period),
    .decim_log2  (decim_log2),
    .resync      (resync),
    .done        (done),
    .done_filt   (done_filt),
    .go          (go),
    .sync_req    (sync_req),
    .running     (running),
    .filt_due    (filt_due),
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt),
    .filt_err    (filt_err),
    .err_clr     (err_clr)
`ifdef LTC2500_SCHED_TIMESTAMP_EN
    ,
    .ts_filt     (ts_filt),
    .ts_valid    (ts_valid)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_at = -1;
  int filt_at = -1;
  int done_lat = 50;
  int filt_lat = 10;
  bit auto_done = 1'b1;
  bit auto_filt = 1'b0;
  int sync_rise = -1;
  int sync_fall = -1;
  logic sync_prev = 1'b0;

  int go_cyc_q[$];
  bit go_filt_q[$];
  int ovr_q[$];
  int exp_cyc_q[$];
  bit exp_filt_q[$];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (go === 1'b1) begin
      go_cyc_q.push_back(cyc);
      go_filt_q.push_back(filt_due);
      if (auto_done) done_at = cyc + done_lat;
      if (auto_filt && filt_due === 1'b1) filt_at = cyc + filt_lat;
    end
    if (overrun === 1'b1) ovr_q.push_back(cyc);
    if (sync_req === 1'b1 && sync_prev !== 1'b1) sync_rise = cyc;
    if (sync_req !== 1'b1 && sync_prev === 1'b1) sync_fall = cyc;
    sync_prev = sync_req;
    done      = (cyc == done_at);
    done_filt = (cyc == filt_at);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; resync = 1'b0; err_clr = 1'b0;
    done = 1'b0; done_filt = 1'b0; done_at = -1; filt_at = -1;
    step();
    step();
    reset = 1'b0;
    go_cyc_q.delete(); go_filt_q.delete(); ovr_q.delete();
    exp_cyc_q.delete(); exp_filt_q.delete();
    sync_rise = -1; sync_fall = -1;
  endtask

  task automatic test_reset();
    period = 99; decim_log2 = 0;
    do_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({go, sync_req, running, filt_due, overrun, filt_err, overrun_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got go=%b sync=%b run=%b fd=%b ovr=%b ferr=%b cnt=%0d want all 0", go, sync_req, running, filt_due, overrun, filt_err, overrun_cnt);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (sync_req !== 1'b0 || running !== 1'b0 || go_cyc_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: got sync=%b run=%b gos=%0d want 0 0 0", sync_req, running, go_cyc_q.size());
    end
  endtask

  task automatic test_startup();
    int ce, nhigh;
    do_reset();
    period = 99; decim_log2 = 0; done_lat = 50; auto_done = 1'b1; auto_filt = 1'b0;
    enable = 1'b1;
    ce = cyc;
    for (int k = 0; k < 5; k++) begin
      exp_cyc_q.push_back(ce + 13 + 100 * k);
      exp_filt_q.push_back(1'b1);
    end
    nhigh = 0;
    for (int i = 0; i < 420; i++) begin
      step();
      if (sync_req === 1'b1) nhigh++;
    end
    checks++;
    if (nhigh != 4) begin errors++; $display("FAIL startup_sync_len: got %0d cycles want 4", nhigh); end
    checks++;
    if (sync_rise != ce + 1) begin errors++; $display("FAIL startup_sync_rise: got cycle %0d want %0d", sync_rise, ce + 1); end
    checks++;
    if (go_cyc_q.size() == 0 || go_cyc_q[0] != sync_fall + 8) begin
      errors++; $display("FAIL startup_guard_gap: sync fell %0d, go count %0d want first go at %0d", sync_fall, go_cyc_q.size(), sync_fall + 8);
    end
    while (exp_cyc_q.size() > 0) begin
      int ec, gc;
      bit ef, gf;
      ec = exp_cyc_q.pop_front(); ef = exp_filt_q.pop_front();
      checks++;
      if (go_cyc_q.size() == 0) begin
        errors++; $display("FAIL startup_go: missing go, want cycle %0d", ec);
      end else begin
        gc = go_cyc_q.pop_front(); gf = go_filt_q.pop_front();
        if (gc != ec || gf != ef) begin errors++; $display("FAIL startup_go: got cycle %0d filt %0b want cycle %0d filt %0b", gc, gf, ec, ef); end
      end
    end
    checks++;
    if (go_cyc_q.size() != 0 || ovr_q.size() != 0) begin
      errors++; $display("FAIL startup_extra: got %0d extra gos %0d overruns want 0 0", go_cyc_q.size(), ovr_q.size());
    end
  endtask

  task automatic test_clamp();
    int ce;
    do_reset();
    period = 10; decim_log2 = 0; done_lat = 20; auto_done = 1'b1; auto_filt = 1'b0;
    enable = 1'b1;
    ce = cyc;
    for (int k = 0; k < 5; k++) begin
      exp_cyc_q.push_back(ce + 13 + 40 * k);
      exp_filt_q.push_back(1'b1);
    end
    for (int i = 0; i < 180; i++) step();
    while (exp_cyc_q.size() > 0) begin
      int ec, gc;
      bit ef, gf;
      ec = exp_cyc_q.pop_front(); ef = exp_filt_q.pop_front();
      checks++;
      if (go_cyc_q.size() == 0) begin
        errors++; $display("FAIL clamp_go: missing go, want cycle %0d", ec);
      end else begin
        gc = go_cyc_q.pop_front(); gf = go_filt_q.pop_front();
        if (gc != ec || gf != ef) begin errors++; $display("FAIL clamp_go: got cycle %0d filt %0b want cycle %0d filt %0b", gc, gf, ec, ef); end
      end
    end
    checks++;
    if (go_cyc_q.size() != 0 || ovr_q.size() != 0) begin
      errors++; $display("FAIL clamp_extra: got %0d extra gos %0d overruns want 0 0", go_cyc_q.size(), ovr_q.size());
    end
  endtask

  task automatic test_overrun();
    int ce, g0;
    do_reset();
    period = 99; decim_log2 = 0; auto_done = 1'b0; auto_filt = 1'b0;
    enable = 1'b1;
    ce = cyc;
    g0 = ce + 13;
    exp_cyc_q.push_back(g0);       exp_filt_q.push_back(1'b1);
    exp_cyc_q.push_back(g0 + 300); exp_filt_q.push_back(1'b1);
    while (cyc < g0) step();
    done_at = g0 + 250;
    while (cyc < g0 + 305) begin
      step();
      if (cyc == g0 + 150) begin
        checks++;
        if (overrun_cnt !== 8'd1) begin errors++; $display("FAIL overrun_cnt_1: got %0d want 1", overrun_cnt); end
      end
    end
    checks++;
    if (ovr_q.size() != 2 || ovr_q[0] != g0 + 100 || ovr_q[1] != g0 + 200) begin
      errors++; $display("FAIL overrun_pulses: got %0d pulses want 2 at %0d and %0d", ovr_q.size(), g0 + 100, g0 + 200);
    end
    checks++;
    if (overrun_cnt !== 8'd2) begin errors++; $display("FAIL overrun_cnt_2: got %0d want 2", overrun_cnt); end
    while (exp_cyc_q.size() > 0) begin
      int ec, gc;
      bit ef, gf;
      ec = exp_cyc_q.pop_front(); ef = exp_filt_q.pop_front();
      checks++;
      if (go_cyc_q.size() == 0) begin
        errors++; $display("FAIL overrun_go: missing go, want cycle %0d", ec);
      end else begin
        gc = go_cyc_q.pop_front(); gf = go_filt_q.pop_front();
        if (gc != ec || gf != ef) begin errors++; $display("FAIL overrun_go: got cycle %0d filt %0b want cycle %0d filt %0b", gc, gf, ec, ef); end
      end
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL overrun_clr: got %0d want 0", overrun_cnt); end
  endtask

  task automatic test_decimation();
    int ce, g0;
    do_reset();
    period = 99; decim_log2 = 3; done_lat = 50; auto_done = 1'b1; auto_filt = 1'b0;
    enable = 1'b1;
    ce = cyc;
    g0 = ce + 13;
    for (int k = 0; k < 16; k++) begin
      exp_cyc_q.push_back(g0 + 100 * k);
      exp_filt_q.push_back((k == 7) || (k == 15));
    end
    while (cyc < g0 + 1505) begin
      step();
      if (cyc == g0 + 955) begin
        checks++;
        if (filt_err !== 1'b0) begin errors++; $display("FAIL decim_err_early: got %b want 0", filt_err); end
      end
      if (cyc == g0 + 956) begin
        checks++;
        if (filt_err !== 1'b1) begin errors++; $display("FAIL decim_err_timeout: got %b want 1", filt_err); end
      end
    end
    while (exp_cyc_q.size() > 0) begin
      int ec, gc;
      bit ef, gf;
      ec = exp_cyc_q.pop_front(); ef = exp_filt_q.pop_front();
      checks++;
      if (go_cyc_q.size() == 0) begin
        errors++; $display("FAIL decim_go: missing go, want cycle %0d", ec);
      end else begin
        gc = go_cyc_q.pop_front(); gf = go_filt_q.pop_front();
        if (gc != ec || gf != ef) begin errors++; $display("FAIL decim_go: got cycle %0d filt %0b want cycle %0d filt %0b", gc, gf, ec, ef); end
      end
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (filt_err !== 1'b0) begin errors++; $display("FAIL decim_err_clr: got %b want 0", filt_err); end
  endtask

  task automatic test_resync();
    int ce, g0, h0;
    do_reset();
    period = 99; decim_log2 = 3; done_lat = 50; filt_lat = 10; auto_done = 1'b1; auto_filt = 1'b1;
    enable = 1'b1;
    ce = cyc;
    g0 = ce + 13;
    h0 = g0 + 264;
    for (int k = 0; k < 3; k++) begin exp_cyc_q.push_back(g0 + 100 * k); exp_filt_q.push_back(1'b0); end
    for (int k = 0; k < 8; k++) begin exp_cyc_q.push_back(h0 + 100 * k); exp_filt_q.push_back(k == 7); end
    while (cyc < g0 + 210) step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL resync_running: got %b want 0", running); end
    while (cyc < g0 + 985) step();
    checks++;
    if (sync_rise != g0 + 252) begin errors++; $display("FAIL resync_sync_rise: got cycle %0d want %0d", sync_rise, g0 + 252); end
    while (exp_cyc_q.size() > 0) begin
      int ec, gc;
      bit ef, gf;
      ec = exp_cyc_q.pop_front(); ef = exp_filt_q.pop_front();
      checks++;
      if (go_cyc_q.size() == 0) begin
        errors++; $display("FAIL resync_go: missing go, want cycle %0d", ec);
      end else begin
        gc = go_cyc_q.pop_front(); gf = go_filt_q.pop_front();
        if (gc != ec || gf != ef) begin errors++; $display("FAIL resync_go: got cycle %0d filt %0b want cycle %0d filt %0b", gc, gf, ec, ef); end
      end
    end
    checks++;
    if (filt_err !== 1'b0 || running !== 1'b1) begin
      errors++; $display("FAIL resync_final: got filt_err=%b running=%b want 0 1", filt_err, running);
    end
  endtask

  task automatic test_reset_mid();
    int ce, g0;
    do_reset();
    period = 99; decim_log2 = 0; done_lat = 50; auto_done = 1'b1; auto_filt = 1'b0;
    enable = 1'b1;
    ce = cyc;
    g0 = ce + 13;
    exp_cyc_q.push_back(g0);      exp_filt_q.push_back(1'b1);
    exp_cyc_q.push_back(g0 + 19); exp_filt_q.push_back(1'b1);
    while (cyc < g0 + 5) step();
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL rstmid_pre_running: got %b want 1", running); end
    reset = 1'b1;
    step();
    checks++;
    if ({go, sync_req, running, filt_due, overrun, filt_err, overrun_cnt} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got go=%b sync=%b run=%b fd=%b ovr=%b ferr=%b cnt=%0d want all 0", go, sync_req, running, filt_due, overrun, filt_err, overrun_cnt);
    end
    reset = 1'b0;
    while (cyc < g0 + 25) step();
    checks++;
    if (sync_rise != g0 + 7) begin errors++; $display("FAIL rstmid_sync_rise: got cycle %0d want %0d", sync_rise, g0 + 7); end
    while (exp_cyc_q.size() > 0) begin
      int ec, gc;
      bit ef, gf;
      ec = exp_cyc_q.pop_front(); ef = exp_filt_q.pop_front();
      checks++;
      if (go_cyc_q.size() == 0) begin
        errors++; $display("FAIL rstmid_go: missing go, want cycle %0d", ec);
      end else begin
        gc = go_cyc_q.pop_front(); gf = go_filt_q.pop_front();
        if (gc != ec || gf != ef) begin errors++; $display("FAIL rstmid_go: got cycle %0d filt %0b want cycle %0d filt %0b", gc, gf, ec, ef); end
      end
    end
    checks++;
    if (go_cyc_q.size() != 0) begin errors++; $display("FAIL rstmid_extra: got %0d extra gos want 0", go_cyc_q.size()); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; resync = 1'b0; err_clr = 1'b0;
    done = 1'b0; done_filt = 1'b0; period = '0; decim_log2 = '0;
    test_reset();
    test_startup();
    test_clamp();
    test_overrun();
    test_decimation();
    test_resync();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
